// File: rtl/common_pkg.sv
// Shared machine-word and memory-size types used across the pipeline.
package common;

  localparam int DATA_W = 64;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [DATA_W-1:0] addr_t;
  typedef logic [4:0]        creg_addr_t;

  // Access width of a load or store.
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-register payloads between execute and memory, plus memory FSM states.
package pipes;
  import common::*;

  typedef struct packed {
    logic   memread;
    logic   memwrite;
    logic   mem_unsigned;
    logic   regwrite;
    msize_t msize;
  } control_t;

  typedef struct packed {
    logic       en;
    addr_t      pc;
    creg_addr_t dst;
    word_t      alu_result;
    word_t      rd2;
    control_t   ctl;
  } excute_data_t;

  typedef struct packed {
    logic       en;
    addr_t      pc;
    addr_t      pcplus4;
    creg_addr_t dst;
    word_t      alu_result;
    word_t      mem_data;
    control_t   ctl;
  } memory_data_t;

  // Data-bus handshake progress of the memory stage.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ma_state_t;

endpackage

// File: rtl/memory_access_load_extend.sv
// Combinational load alignment: pick the addressed lanes out of the 64-bit
// read word and zero- or sign-extend them to a full word.
module load_extend
  import common::*;
(
  input  word_t      data_i,
  input  logic [2:0] offset_i,
  input  msize_t     size_i,
  input  logic       unsigned_i,
  output word_t      result_o
);

  // Extend a right-justified value of the given byte width to 64 bits.
  function automatic word_t extend(input word_t v, input msize_t sz, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    word_t              r;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    unique case (sz)
      MSIZE1:  r = uns ? {56'd0, v[7:0]}  : word_t'(64'(b));
      MSIZE2:  r = uns ? {48'd0, v[15:0]} : word_t'(64'(h));
      MSIZE4:  r = uns ? {32'd0, v[31:0]} : word_t'(64'(w));
      default: r = v;
    endcase
    return r;
  endfunction

  word_t shifted;

  // Move the addressed byte lane down to bit 0, then extend.
  always_comb begin
    shifted  = data_i >> {offset_i, 3'b000};
    result_o = extend(shifted, size_i, unsigned_i);
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: passes non-memory instructions through in one cycle and
// runs a two-phase (address, data) bus handshake for loads and stores,
// stalling upstream until the access completes.
module memory_access
  import common::*;
  import pipes::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t in,
  output memory_data_t out,
  output logic         stall,
  input  logic         flush,
  output logic         dreq_valid,
  output addr_t        dreq_addr,
  output msize_t       dreq_size,
  output logic [7:0]   dreq_strobe,
  output word_t        dreq_data,
  input  logic         dresp_addr_ok,
  input  logic         dresp_data_ok,
  input  word_t        dresp_data
);

  function automatic logic is_mem(input excute_data_t e);
    return e.ctl.memread | e.ctl.memwrite;
  endfunction

  function automatic memory_data_t pack_out(input excute_data_t src, input word_t mem_data);
    memory_data_t o;
    o.en         = src.en;
    o.pc         = src.pc;
    o.pcplus4    = src.pc + 64'd4;
    o.dst        = src.dst;
    o.alu_result = src.alu_result;
    o.mem_data   = mem_data;
    o.ctl        = src.ctl;
    return o;
  endfunction

  ma_state_t    state_q;
  excute_data_t lat_q;
  memory_data_t out_q, out_d;
  logic [2:0]   lane;
  logic [7:0]   strobe;
  word_t        load_data;
  logic         done;

  assign lane = lat_q.alu_result[2:0];

  load_extend u_load_extend (
    .data_i     (dresp_data),
    .offset_i   (lane),
    .size_i     (lat_q.ctl.msize),
    .unsigned_i (lat_q.ctl.mem_unsigned),
    .result_o   (load_data)
  );

  // Byte-lane write enables; lanes shifted past bit 7 fall off the top.
  always_comb begin
    strobe = 8'h00;
    if (lat_q.ctl.memwrite) begin
      unique case (lat_q.ctl.msize)
        MSIZE1:  strobe = 8'h01 << lane;
        MSIZE2:  strobe = 8'h03 << lane;
        MSIZE4:  strobe = 8'h0F << lane;
        default: strobe = 8'hFF;
      endcase
    end
  end

  // Bus request is driven purely from the latched instruction, so it stays
  // stable for the whole handshake regardless of what upstream presents.
  assign dreq_valid  = (state_q != IDLE);
  assign dreq_addr   = lat_q.alu_result;
  assign dreq_size   = lat_q.ctl.msize;
  assign dreq_strobe = strobe;
  assign dreq_data   = lat_q.rd2 << {lane, 3'b000};
  assign stall       = (state_q != IDLE);

  assign done = ((state_q == ADDR) && dresp_addr_ok && dresp_data_ok) ||
                ((state_q == DATA) && dresp_data_ok);

  // Next output register value: bypass, completed access, or bubble; flush wins.
  always_comb begin
    out_d = '0;
    if ((state_q == IDLE) && in.en && !is_mem(in)) begin
      out_d = pack_out(in, '0);
    end else if (done) begin
      out_d = pack_out(lat_q, lat_q.ctl.memread ? load_data : '0);
    end
    if (flush) begin
      out_d.en = 1'b0;
    end
  end

  // Handshake FSM with registered stage output; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      out_q   <= '0;
    end else begin
      out_q <= out_d;
      unique case (state_q)
        IDLE: begin
          if (in.en && is_mem(in)) begin
            lat_q   <= in;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (dresp_addr_ok) begin
            state_q <= dresp_data_ok ? IDLE : DATA;
          end
        end
        DATA: begin
          if (dresp_data_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for the memory stage: bypass path, loads with extension,
// store lanes with a slow bus, stall/replay, reset and flush.
module tb_memory_access;
  import common::*;
  import pipes::*;

  logic         clk = 1'b0;
  logic         reset;
  excute_data_t in;
  memory_data_t out;
  logic         stall;
  logic         flush;
  logic         dreq_valid;
  addr_t        dreq_addr;
  msize_t       dreq_size;
  logic [7:0]   dreq_strobe;
  word_t        dreq_data;
  logic         dresp_addr_ok;
  logic         dresp_data_ok;
  word_t        dresp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk           (clk),
    .reset         (reset),
    .in            (in),
    .out           (out),
    .stall         (stall),
    .flush         (flush),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data)
  );

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic excute_data_t mk(input addr_t pc, input creg_addr_t dst, input word_t alu,
                                      input word_t rd2, input logic rd, input logic wr,
                                      input logic uns, input msize_t sz);
    excute_data_t e;
    e.en               = 1'b1;
    e.pc               = pc;
    e.dst              = dst;
    e.alu_result       = alu;
    e.rd2              = rd2;
    e.ctl.memread      = rd;
    e.ctl.memwrite     = wr;
    e.ctl.mem_unsigned = uns;
    e.ctl.regwrite     = rd | ~wr;
    e.ctl.msize        = sz;
    return e;
  endfunction

  // Issue a single-cycle-acked load and return the extended result.
  task automatic quick_load(input string tag, input word_t addr, input msize_t sz,
                            input logic uns, input word_t bus, input word_t exp);
    in = mk(64'h8000_0100, 5'd3, addr, 64'd0, 1'b1, 1'b0, uns, sz);
    tick();
    in = '0;
    chk({tag, "_stall"}, stall, 1'b1);
    chk({tag, "_addr"}, dreq_addr, addr);
    chk({tag, "_strobe"}, dreq_strobe, 8'h00);
    dresp_data = bus; dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk({tag, "_en"}, out.en, 1'b1);
    chk({tag, "_data"}, out.mem_data, exp);
    chk({tag, "_idle"}, stall, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    tick(); tick();
    chk("rst_out", out, '0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_valid", dreq_valid, 1'b0);
    reset = 1'b1;

    // ALU instruction: one-cycle bypass.
    in = mk(64'h8000_0000, 5'd5, 64'h10, 64'd0, 1'b0, 1'b0, 1'b0, MSIZE8);
    chk("add_stall_pre", stall, 1'b0);
    tick();
    in = '0;
    chk("add_en", out.en, 1'b1);
    chk("add_alu", out.alu_result, 64'h10);
    chk("add_pc4", out.pcplus4, 64'h8000_0004);
    chk("add_dst", out.dst, 5'd5);
    chk("add_mem", out.mem_data, 64'd0);
    chk("add_stall", stall, 1'b0);
    tick();
    chk("bubble_en", out.en, 1'b0);

    // LB / LBU at offset 3.
    quick_load("lb",  64'h1003, MSIZE1, 1'b0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    quick_load("lbu", 64'h1003, MSIZE1, 1'b1, 64'h0000_0000_8000_0000, 64'h80);
    quick_load("lh",  64'h1002, MSIZE2, 1'b0, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);

    // SH at offset 6 against a slow bus: 3 waits, addr_ok, 2 waits, data_ok.
    in = mk(64'h8000_0200, 5'd0, 64'h2006, 64'hBEEF, 1'b0, 1'b1, 1'b0, MSIZE2);
    tick();
    in = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) dresp_addr_ok = 1'b1;
      chk($sformatf("sh_valid%0d", i), dreq_valid, 1'b1);
      chk($sformatf("sh_stall%0d", i), stall, 1'b1);
      chk($sformatf("sh_strobe%0d", i), dreq_strobe, 8'hC0);
      chk($sformatf("sh_data%0d", i), dreq_data, 64'hBEEF_0000_0000_0000);
      chk($sformatf("sh_addr%0d", i), dreq_addr, 64'h2006);
      chk($sformatf("sh_oen%0d", i), out.en, 1'b0);
      tick();
      dresp_addr_ok = 1'b0;
    end
    dresp_data_ok = 1'b1;
    chk("sh_last_stall", stall, 1'b1);
    tick();
    dresp_data_ok = 1'b0;
    chk("sh_en", out.en, 1'b1);
    chk("sh_mem", out.mem_data, 64'd0);
    chk("sh_stall_done", stall, 1'b0);

    // SW at offset 6: upper lanes fall off; SD uses all lanes.
    in = mk(64'h8000_0300, 5'd0, 64'h2016, 64'h1122_3344, 1'b0, 1'b1, 1'b0, MSIZE4);
    tick();
    in = '0;
    chk("sw_strobe", dreq_strobe, 8'hC0);
    chk("sw_data", dreq_data, 64'h3344_0000_0000_0000);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    in = mk(64'h8000_0304, 5'd0, 64'h2020, 64'hA5A5_0000_0000_5A5A, 1'b0, 1'b1, 1'b0, MSIZE8);
    tick();
    in = '0;
    chk("sd_strobe", dreq_strobe, 8'hFF);
    chk("sd_data", dreq_data, 64'hA5A5_0000_0000_5A5A);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;

    // LW at offset 4 with an ADDI held upstream during the stall.
    in = mk(64'h8000_0400, 5'd6, 64'h3004, 64'd0, 1'b1, 1'b0, 1'b0, MSIZE4);
    tick();
    in = mk(64'h8000_0404, 5'd7, 64'h42, 64'd0, 1'b0, 1'b0, 1'b0, MSIZE8);
    chk("lw_stall", stall, 1'b1);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    chk("lw_data_stall", stall, 1'b1);
    chk("lw_oen_wait", out.en, 1'b0);
    dresp_data = 64'h1234_5678_0000_0000; dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    chk("lw_en", out.en, 1'b1);
    chk("lw_mem", out.mem_data, 64'h1234_5678);
    chk("lw_dst", out.dst, 5'd6);
    chk("lw_stall_done", stall, 1'b0);
    tick();
    in = '0;
    chk("addi_en", out.en, 1'b1);
    chk("addi_dst", out.dst, 5'd7);
    chk("addi_alu", out.alu_result, 64'h42);
    tick();
    chk("addi_once_a", out.en, 1'b0);
    tick();
    chk("addi_once_b", out.en, 1'b0);

    // Reset while waiting in DATA, then a fresh LD.
    in = mk(64'h8000_0500, 5'd8, 64'h4000, 64'd0, 1'b1, 1'b0, 1'b0, MSIZE8);
    tick();
    in = '0;
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    chk("rd_in_data", stall, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rmid_valid", dreq_valid, 1'b0);
    chk("rmid_stall", stall, 1'b0);
    chk("rmid_out", out, '0);
    quick_load("ld", 64'h4008, MSIZE8, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // Flush on the data_ok cycle.
    in = mk(64'h8000_0600, 5'd9, 64'h5000, 64'd0, 1'b1, 1'b0, 1'b0, MSIZE8);
    tick();
    in = '0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; flush = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; flush = 1'b0;
    chk("flush_en", out.en, 1'b0);
    chk("flush_stall", stall, 1'b0);
    chk("flush_valid", dreq_valid, 1'b0);
    in = mk(64'h8000_0700, 5'd10, 64'h99, 64'd0, 1'b0, 1'b0, 1'b0, MSIZE8);
    tick();
    in = '0;
    chk("post_flush_en", out.en, 1'b1);
    chk("post_flush_alu", out.alu_result, 64'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
